// File: rtl/vproc_pkg.sv
// Shared types for the vproc memory reader: FSM state encoding and
// a width helper for occupancy counters.
package vproc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } mem_reader_state_e;

  // Bits needed to hold a count of 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vproc_mem_reader_if.sv
// Command, memory-request and data-stream signals of the memory reader.
// Signal suffixes are from the reader's point of view.
interface vproc_mem_reader_if #(
  parameter int unsigned MEM_W = 32,
  parameter int unsigned CNT_W = 16
);

  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic [31:0]          cmd_addr_i;
  logic [CNT_W-1:0]     cmd_len_i;

  logic                 mem_req_o;
  logic [31:0]          mem_addr_o;
  logic                 mem_we_o;
  logic [MEM_W/8-1:0]   mem_be_o;
  logic [MEM_W-1:0]     mem_wdata_o;
  logic                 mem_rvalid_i;
  logic                 mem_err_i;
  logic [MEM_W-1:0]     mem_rdata_i;

  logic                 data_valid_o;
  logic                 data_ready_i;
  logic [MEM_W-1:0]     data_o;
  logic                 data_err_o;
  logic                 data_last_o;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_len_i,
    input  mem_rvalid_i, mem_err_i, mem_rdata_i,
    input  data_ready_i,
    output cmd_ready_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output data_valid_o, data_o, data_err_o, data_last_o
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_len_i,
    output mem_rvalid_i, mem_err_i, mem_rdata_i,
    output data_ready_i,
    input  cmd_ready_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  data_valid_o, data_o, data_err_o, data_last_o
  );

endinterface

// File: rtl/vproc_mem_reader_fifo.sv
// Synchronous response FIFO with occupancy count; entries hold
// {error flag, data}. Async active-high reset clears storage too.
module vproc_mem_reader_fifo
  import vproc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 33
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            wdata_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            rdata_o,
  output logic                        empty_o,
  output logic [cnt_width(DEPTH)-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign do_push = push_i && (count_q != FULL_CNT);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vproc_mem_reader.sv
// Streams a contiguous block of words from memory onto a valid/ready stream.
// Optional macro VPROC_MEM_READER_ERR_ABORT_EN: stop issuing at the first error.
module vproc_mem_reader
  import vproc_pkg::*;
#(
  parameter int unsigned MEM_W      = 32,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  vproc_mem_reader_if.master  bus,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int unsigned    CW         = cnt_width(FIFO_DEPTH);
  localparam logic [31:0]    WORD_BYTES = 32'(MEM_W / 8);
  localparam logic [CW:0]    CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LEN_ONE  = CNT_W'(1);

  mem_reader_state_e state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic              req_q, req_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic              issue;
  logic              resp_accept;
  logic              abort;
  logic              credit_ok;
  logic              data_valid;
  logic              data_last;
  logic              beat_pop;
  logic [MEM_W:0]    fifo_rdata;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  // Responses with nothing in flight (e.g. stragglers after reset) are dropped.
  assign resp_accept = bus.mem_rvalid_i && (outstanding_q != '0);
  assign credit_ok   = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < CREDIT_MAX;
  assign data_valid  = !fifo_empty;
  assign data_last   = data_valid && (state_q == DRAIN) &&
                       (outstanding_q == '0) && (fifo_count == CW'(1));
  assign beat_pop    = data_valid && bus.data_ready_i;

`ifdef VPROC_MEM_READER_ERR_ABORT_EN
  assign abort = resp_accept && bus.mem_err_i;
`else
  assign abort = 1'b0;
`endif

  vproc_mem_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (MEM_W + 1)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (resp_accept),
    .wdata_i ({bus.mem_err_i, bus.mem_rdata_i}),
    .pop_i   (beat_pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // The first request is launched straight from the accept cycle so it
  // appears on the bus one cycle after the command handshake.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    req_d       = 1'b0;
    mem_addr_d  = mem_addr_q;
    err_d       = err_q;
    done_d      = 1'b0;
    issue       = 1'b0;

    if (resp_accept && bus.mem_err_i) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          err_d = 1'b0;
          if (bus.cmd_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            issue       = 1'b1;
            req_d       = 1'b1;
            mem_addr_d  = bus.cmd_addr_i;
            addr_d      = bus.cmd_addr_i + WORD_BYTES;
            remaining_d = bus.cmd_len_i - LEN_ONE;
            state_d     = (bus.cmd_len_i == LEN_ONE) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = DRAIN;
        end else if ((remaining_q != '0) && credit_ok) begin
          issue       = 1'b1;
          req_d       = 1'b1;
          mem_addr_d  = addr_q;
          addr_d      = addr_q + WORD_BYTES;
          remaining_d = remaining_q - LEN_ONE;
          if (remaining_q == LEN_ONE) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (beat_pop && data_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    case ({issue, resp_accept})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      req_q         <= 1'b0;
      mem_addr_q    <= '0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      req_q         <= req_d;
      mem_addr_q    <= mem_addr_d;
      err_q         <= err_d;
      done_q        <= done_d;
    end
  end

  assign bus.cmd_ready_o  = (state_q == IDLE);
  assign bus.mem_req_o    = req_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_we_o     = 1'b0;
  assign bus.mem_be_o     = '1;
  assign bus.mem_wdata_o  = '0;
  assign bus.data_valid_o = data_valid;
  assign bus.data_o       = fifo_rdata[MEM_W-1:0];
  assign bus.data_err_o   = fifo_rdata[MEM_W];
  assign bus.data_last_o  = data_last;

  assign busy_o = (state_q != IDLE) || done_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_vproc_mem_reader.sv
// Directed testbench for vproc_mem_reader with a fixed-latency in-order
// memory model; data returned for an address is addr ^ 32'hDEAD_BEEF.
module tb_vproc_mem_reader;

  localparam logic [31:0] MAGIC = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        last;
    int          cyc;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic clk;
  logic rst;
  logic busy;
  logic done;
  logic err;

  vproc_mem_reader_if #(.MEM_W(32), .CNT_W(16)) bus ();

  vproc_mem_reader #(
    .MEM_W      (32),
    .CNT_W      (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus.master),
    .busy_o (busy),
    .done_o (done),
    .err_o  (err)
  );

  int          cyc = 0;
  int          lat = 1;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          acc_cyc = 0;
  int          done_cyc = 0;
  logic [31:0] req_addrs [$];
  int          req_cycs [$];
  beat_t       beats [$];
  pend_t       pend [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: in-order responses exactly lat cycles after each request
  initial begin
    pend_t p;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_err_i    = 1'b0;
    bus.mem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.mem_req_o) pend.push_back('{bus.mem_addr_o, cyc + lat});
      bus.mem_rvalid_i = 1'b0;
      bus.mem_err_i    = 1'b0;
      bus.mem_rdata_i  = '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = p.addr ^ MAGIC;
        bus.mem_err_i    = err_en && (p.addr == err_addr);
      end
    end
  end

  // Request / beat / done logger
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.mem_req_o) begin
        req_addrs.push_back(bus.mem_addr_o);
        req_cycs.push_back(cyc);
      end
      if (bus.data_valid_o && bus.data_ready_i)
        beats.push_back('{bus.data_o, bus.data_err_o, bus.data_last_o, cyc});
      if (done) done_cnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clearLogs();
    req_addrs.delete();
    req_cycs.delete();
    beats.delete();
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [15:0] len);
    @(posedge clk);
    #1;
    checkOutput("cmd_ready_before_accept", bus.cmd_ready_o, 1'b1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_addr_i  = addr;
    bus.cmd_len_i   = len;
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int   start;
    logic seen;
    start = done_cnt;
    seen  = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen     = 1'b1;
        done_cyc = cyc;
      end
    end
    if (!seen) begin
      checkOutput({tag, "_done_timeout"}, 1'b0, 1'b1);
    end else begin
      checkOutput({tag, "_busy_in_done_cycle"}, busy, 1'b1);
      @(negedge clk);
      checkOutput({tag, "_done_pulse_width"}, done, 1'b0);
      checkOutput({tag, "_busy_after_done"}, busy, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput({tag, "_done_count"}, 64'(done_cnt - start), 64'd1);
    end
  endtask

  task automatic checkStream(input string tag, input logic [31:0] base, input int n, input int err_idx);
    logic [31:0] ea;
    checkOutput({tag, "_req_count"}, 64'(req_addrs.size()), 64'(n));
    checkOutput({tag, "_beat_count"}, 64'(beats.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      ea = base + 32'(4 * i);
      if (i < req_addrs.size())
        checkOutput($sformatf("%s_req_addr[%0d]", tag, i), req_addrs[i], ea);
      if (i < beats.size()) begin
        checkOutput($sformatf("%s_data[%0d]", tag, i), beats[i].data, ea ^ MAGIC);
        checkOutput($sformatf("%s_err[%0d]", tag, i), beats[i].err, 1'(i == err_idx));
        checkOutput($sformatf("%s_last[%0d]", tag, i), beats[i].last, 1'(i == n - 1));
      end
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_cmd_ready"}, bus.cmd_ready_o, 1'b1);
    checkOutput({tag, "_mem_req"}, bus.mem_req_o, 1'b0);
    checkOutput({tag, "_mem_addr"}, bus.mem_addr_o, 32'h0);
    checkOutput({tag, "_data_valid"}, bus.data_valid_o, 1'b0);
    checkOutput({tag, "_data"}, bus.data_o, 32'h0);
    checkOutput({tag, "_data_err"}, bus.data_err_o, 1'b0);
    checkOutput({tag, "_data_last"}, bus.data_last_o, 1'b0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    int n_err;
    int start_done;
    rst = 1'b1;
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_addr_i   = '0;
    bus.cmd_len_i    = '0;
    bus.data_ready_i = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    checkOutput("reset_we", bus.mem_we_o, 1'b0);
    checkOutput("reset_be", bus.mem_be_o, 4'hF);
    checkOutput("reset_wdata", bus.mem_wdata_o, 32'h0);
    rst = 1'b0;

    $display("[TB] test 1: 8 words from 0x100, latency 1");
    clearLogs();
    lat = 1;
    applyStimulus(32'h100, 16'd8);
    waitDone("t1", 100);
    checkStream("t1", 32'h100, 8, -1);
    if (req_cycs.size() == 8) begin
      checkOutput("t1_first_req_cycle", 64'(req_cycs[0]), 64'(acc_cyc + 1));
      checkOutput("t1_back_to_back", 64'(req_cycs[7] - req_cycs[0]), 64'd7);
    end
    if (beats.size() == 8)
      checkOutput("t1_done_after_last", 64'(done_cyc), 64'(beats[7].cyc + 1));
    checkOutput("t1_err", err, 1'b0);

    $display("[TB] test 2: latency 3, consumer stalled");
    clearLogs();
    lat = 3;
    bus.data_ready_i = 1'b0;
    applyStimulus(32'h200, 16'd8);
    repeat (12) @(negedge clk);
    checkOutput("t2_stalled_req_count", 64'(req_addrs.size()), 64'd4);
    checkOutput("t2_stalled_beats", 64'(beats.size()), 64'd0);
    checkOutput("t2_stalled_valid", bus.data_valid_o, 1'b1);
    checkOutput("t2_stalled_data", bus.data_o, 32'h200 ^ MAGIC);
    repeat (3) @(negedge clk);
    checkOutput("t2_held_data", bus.data_o, 32'h200 ^ MAGIC);
    checkOutput("t2_held_last", bus.data_last_o, 1'b0);
    @(posedge clk);
    #1;
    bus.data_ready_i = 1'b1;
    waitDone("t2", 100);
    checkStream("t2", 32'h200, 8, -1);

    $display("[TB] test 3: zero length");
    clearLogs();
    lat = 1;
    applyStimulus(32'h240, 16'd0);
    waitDone("t3", 20);
    checkOutput("t3_done_cycle", 64'(done_cyc), 64'(acc_cyc + 1));
    checkOutput("t3_req_count", 64'(req_addrs.size()), 64'd0);
    checkOutput("t3_beat_count", 64'(beats.size()), 64'd0);

    $display("[TB] test 4: error on word 3 of 6");
    clearLogs();
    err_en   = 1'b1;
    err_addr = 32'h308;
`ifdef VPROC_MEM_READER_ERR_ABORT_EN
    n_err = 4;
`else
    n_err = 6;
`endif
    applyStimulus(32'h300, 16'd6);
    waitDone("t4", 100);
    checkStream("t4", 32'h300, n_err, 2);
    checkOutput("t4_err_sticky", err, 1'b1);
    err_en = 1'b0;

    $display("[TB] test 5: address wrap from 0xFFFFFFF8");
    clearLogs();
    applyStimulus(32'hFFFF_FFF8, 16'd4);
    checkOutput("t5_err_cleared", err, 1'b0);
    waitDone("t5", 100);
    checkStream("t5", 32'hFFFF_FFF8, 4, -1);
    if (req_addrs.size() == 4) begin
      checkOutput("t5_wrap_addr2", req_addrs[2], 32'h0);
      checkOutput("t5_wrap_addr3", req_addrs[3], 32'h4);
    end

    $display("[TB] test 6: reset with two requests in flight");
    clearLogs();
    lat = 6;
    start_done = done_cnt;
    applyStimulus(32'h400, 16'd8);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("t6_req_before_reset", 64'(req_addrs.size()), 64'd2);
    checkOutput("t6_beats_after_reset", 64'(beats.size()), 64'd0);
    checkOutput("t6_no_done", 64'(done_cnt - start_done), 64'd0);
    checkIdleOutputs("t6_post_reset");
    clearLogs();
    lat = 1;
    applyStimulus(32'h500, 16'd2);
    waitDone("t6b", 50);
    checkStream("t6b", 32'h500, 2, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got 0, expected 1");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
